// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronizes and debounces a mechanical push-button, reporting
//            the debounced level, press/release/long-press strobes and the
//            length of the last completed press.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gpio_in,
    output logic        pressed,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_pulse,
    output logic [31:0] press_len
);

    localparam int unsigned           c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]    c_DB_TARGET = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [31:0]           c_LONG      = 32'(LONG_PRESS_CYCLES);
    localparam logic [31:0]           c_DUR_MAX   = 32'hFFFF_FFFF;
    localparam logic                  c_IDLE_PIN  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; resets to the released pin level so that no
    // phantom press is seen when reset is removed.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= c_IDLE_PIN;
            r_sync2 <= c_IDLE_PIN;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level = r_sync2 ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Debounce state machine
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_press_evt;
    logic                 w_rel_evt;
    logic                 w_dur_clear;
    logic                 w_active;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;
    assign w_active  = (r_state == ST_HELD) || (r_state == ST_RELEASE_WAIT);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press_evt  = 1'b0;
        w_rel_evt    = 1'b0;
        w_dur_clear  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_level) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                        w_press_evt  = 1'b1;
                        w_dur_clear  = 1'b1;
                    end else begin
                        w_state_next = ST_PRESS_WAIT;
                        w_cnt_next   = c_CNT_ONE;
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_level) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == c_DB_TARGET) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                    w_press_evt  = 1'b1;
                    w_dur_clear  = 1'b1;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!w_level) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                        w_rel_evt    = 1'b1;
                    end else begin
                        w_state_next = ST_RELEASE_WAIT;
                        w_cnt_next   = c_CNT_ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_level) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == c_DB_TARGET) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_rel_evt    = 1'b1;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Press duration: w_dur_now is the elapsed count including the
    // current cycle, so a press held N cycles reports N.
    // ------------------------------------------------------------------
    logic [31:0] r_dur;
    logic [31:0] w_dur_now;
    logic        r_long_done;
    logic        w_long_evt;

    assign w_dur_now  = (r_dur == c_DUR_MAX) ? c_DUR_MAX : (r_dur + 32'd1);
    assign w_long_evt = w_active && (w_dur_now == c_LONG) && !r_long_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dur       <= '0;
            r_long_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_dur_clear) begin
                r_dur <= '0;
            end else if (w_active) begin
                r_dur <= w_dur_now;
            end
            // Guards against repeat firing once the counter saturates
            if (w_dur_clear) begin
                r_long_done <= 1'b0;
            end else if (w_long_evt) begin
                r_long_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event stage followed by the registered output stage
    // ------------------------------------------------------------------
    logic        r_press_evt;
    logic        r_rel_evt;
    logic        r_long_evt;
    logic [31:0] r_len_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_evt <= 1'b0;
            r_rel_evt   <= 1'b0;
            r_long_evt  <= 1'b0;
            r_len_s1    <= '0;
        end else begin
            r_press_evt <= w_press_evt;
            r_rel_evt   <= w_rel_evt;
            r_long_evt  <= w_long_evt;
            if (w_rel_evt) begin
                r_len_s1 <= w_dur_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_len     <= '0;
        end else begin
            pressed       <= w_active;
            press_pulse   <= r_press_evt;
            release_pulse <= r_rel_evt;
            long_pulse    <= r_long_evt;
            if (r_rel_evt) begin
                press_len <= r_len_s1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench for button_debounce (DEBOUNCE_CYCLES=4,
//            LONG_PRESS_CYCLES=20, ACTIVE_LOW=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 20;
    localparam bit          AL = 1'b1;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        gpio_in = AL;
    logic        pressed;
    logic        press_pulse;
    logic        release_pulse;
    logic        long_pulse;
    logic [31:0] press_len;

    button_debounce #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .ACTIVE_LOW        (AL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gpio_in       (gpio_in),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_len     (press_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the accepted level flips after DB consecutive
    // samples disagreeing with it; events become visible two edges later.
    // ------------------------------------------------------------------
    logic            m_s1, m_s2, m_acc, m_long_done;
    int unsigned     m_run;
    longint unsigned m_dur;
    logic [31:0]     m_len;
    logic            p_press, p_rel, p_long, p_pressed;
    logic [31:0]     p_len;
    logic            e_press, e_rel, e_long, e_pressed;
    logic [31:0]     e_len;

    task automatic model_step();
        logic lvl;
        if (!rst_n) begin
            m_s1 = AL; m_s2 = AL; m_acc = 1'b0; m_run = 0; m_dur = 0;
            m_long_done = 1'b0; m_len = '0;
            p_press = 0; p_rel = 0; p_long = 0; p_pressed = 0; p_len = '0;
            e_press = 0; e_rel = 0; e_long = 0; e_pressed = 0; e_len = '0;
        end else begin
            e_press = p_press; e_rel = p_rel; e_long = p_long;
            e_pressed = p_pressed; e_len = p_len;
            lvl = m_s2 ^ AL;
            p_press = 0; p_rel = 0; p_long = 0;
            if (m_acc) begin
                if (m_dur < 64'hFFFF_FFFF) m_dur++;
                if (m_dur == LP && !m_long_done) begin
                    p_long = 1'b1;
                    m_long_done = 1'b1;
                end
            end
            if (lvl != m_acc) begin
                m_run++;
                if (m_run == DB) begin
                    m_run = 0;
                    if (m_acc) begin
                        p_rel = 1'b1;
                        m_len = 32'(m_dur);
                    end else begin
                        p_press = 1'b1;
                        m_dur = 0;
                        m_long_done = 1'b0;
                    end
                    m_acc = ~m_acc;
                end
            end else begin
                m_run = 0;
            end
            p_pressed = m_acc;
            p_len = m_len;
            m_s2 = m_s1;
            m_s1 = gpio_in;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle compare plus event counters used by directed checks
    int          n_press, n_rel, n_long, n_len_chg;
    logic [31:0] prev_len = '0;

    initial forever begin
        @(negedge clk);
        check("pressed",       pressed,       e_pressed);
        check("press_pulse",   press_pulse,   e_press);
        check("release_pulse", release_pulse, e_rel);
        check("long_pulse",    long_pulse,    e_long);
        check("press_len",     press_len,     e_len);
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_long  += int'(long_pulse);
        if (press_len != prev_len) n_len_chg++;
        prev_len = press_len;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int f_press, f_rel, f_long, f_pressed;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_long = 0; n_len_chg = 0;
    endtask

    // Press for low1 edges, bounce released for high1, press again for low2,
    // then release; records the first edge index each output is seen high.
    task automatic play(input int low1, input int high1, input int low2, input int total);
        f_press = -1; f_rel = -1; f_long = -1; f_pressed = -1;
        clear_counts();
        for (int k = 0; k < total; k++) begin
            if (k < low1)                     gpio_in = AL ^ 1'b1;
            else if (k < low1 + high1)        gpio_in = AL;
            else if (k < low1 + high1 + low2) gpio_in = AL ^ 1'b1;
            else                              gpio_in = AL;
            tick(1);
            if (press_pulse   && f_press   < 0) f_press   = k;
            if (release_pulse && f_rel     < 0) f_rel     = k;
            if (long_pulse    && f_long    < 0) f_long    = k;
            if (pressed       && f_pressed < 0) f_pressed = k;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(3);
        check("reset pressed",   pressed,       0);
        check("reset press_p",   press_pulse,   0);
        check("reset release_p", release_pulse, 0);
        check("reset long_p",    long_pulse,    0);
        check("reset press_len", press_len,     0);
        rst_n = 1'b1;
        tick(5);

        // Short press: 10 cycles
        play(10, 0, 0, 30);
        check("A press edge",    f_press,   6);
        check("A pressed edge",  f_pressed, 6);
        check("A release edge",  f_rel,     16);
        check("A press_len",     press_len, 10);
        check("A long count",    n_long,    0);
        check("A press count",   n_press,   1);
        check("A release count", n_rel,     1);
        check("A len changes",   n_len_chg, 1);

        // Glitch shorter than the debounce window
        play(3, 0, 0, 15);
        check("B press count",  n_press,   0);
        check("B pressed edge", f_pressed, -1);

        // Long press: 50 cycles
        play(50, 0, 0, 70);
        check("C long count",   n_long,    1);
        check("C long edge",    f_long,    26);
        check("C release edge", f_rel,     56);
        check("C press_len",    press_len, 50);

        // Release bounce while releasing
        play(30, 2, 3, 50);
        check("D press count",   n_press,   1);
        check("D release count", n_rel,     1);
        check("D release edge",  f_rel,     41);
        check("D press_len",     press_len, 35);

        // Release accepted in the same cycle the long threshold is reached
        play(20, 0, 0, 40);
        check("E long edge",    f_long,    26);
        check("E release edge", f_rel,     26);
        check("E press_len",    press_len, 20);

        // Reset while held
        gpio_in = AL ^ 1'b1;
        tick(15);
        check("F pressed pre-reset", pressed, 1);
        clear_counts();
        #2 rst_n = 1'b0;
        #1;
        check("F async pressed",   pressed,       0);
        check("F async press_p",   press_pulse,   0);
        check("F async release_p", release_pulse, 0);
        check("F async long_p",    long_pulse,    0);
        check("F async press_len", press_len,     0);
        tick(2);
        rst_n = 1'b1;
        f_press = -1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (press_pulse && f_press < 0) f_press = k;
        end
        check("F re-press edge",     f_press,   6);
        check("F release count",     n_rel,     0);
        check("F press_len held",    press_len, 0);
        gpio_in = AL;
        tick(12);
        check("F final release count", n_rel,     1);
        check("F final press_len",     press_len, 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, consecutive stable samples (20 ms at 50 MHz) required to accept a level change; legal range 1 to 2^24.
REQ-002 Parameter: LONG_PRESS_CYCLES, default 50000000, held duration (1 s at 50 MHz) at which long_pulse fires; legal range 1 to 2^32-1.
REQ-003 Parameter: ACTIVE_LOW, default 1, 1 = pin reads 0 when pressed.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 gpio_in  input  1  raw pin from GPIO header, asynchronous, may bounce.
REQ-007 pressed  output  1  debounced press level, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-010 long_pulse  output  1  one-cycle strobe when a press reaches LONG_PRESS_CYCLES.
REQ-011 press_len  output  32  duration of last completed press in clk cycles, held until next release.

Function
REQ-012 gpio_in SHALL pass through a two-flop synchronizer; normalized level = synchronized value XOR ACTIVE_LOW (1 = pressed).
REQ-013 Synchronizer flops SHALL reset to the not-pressed pin value so no press is seen after reset release.
REQ-014 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; all outputs registered.
REQ-015 IDLE: level=1 -> PRESS_WAIT with debounce count = 1; else stay.
REQ-016 PRESS_WAIT: level=0 -> IDLE, no output (glitch rejected); level=1 -> count+1; when the DEBOUNCE_CYCLES-th consecutive level=1 sample is taken -> HELD, press_pulse=1 and pressed=1 in the next cycle, duration counter cleared to 0.
REQ-017 DEBOUNCE_CYCLES=1: IDLE level=1 SHALL go directly to HELD with press_pulse.
REQ-018 Latency: with gpio_in stable pressed before rising edge 0, press_pulse SHALL be high exactly between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3; release path symmetric.
REQ-019 HELD: duration counter increments by 1 every cycle, saturating at 2^32-1 (no wrap); level=0 -> RELEASE_WAIT with debounce count = 1.
REQ-020 RELEASE_WAIT: duration keeps counting; level=1 -> HELD with no pulse (bounce rejected, pressed stays 1); DEBOUNCE_CYCLES-th consecutive level=0 sample -> IDLE, release_pulse=1, pressed=0, press_len <= duration counter value in that cycle.
REQ-021 long_pulse SHALL fire exactly once per press, in the cycle the duration counter equals LONG_PRESS_CYCLES, in HELD or RELEASE_WAIT; never if released first.
REQ-022 long_pulse and release_pulse in the same cycle SHALL both assert.
REQ-023 press_pulse, release_pulse, long_pulse SHALL each be high for exactly one cycle per event, never two consecutive cycles.
REQ-024 press_len SHALL change only on release_pulse cycles.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, counters 0, pressed=0, all pulses 0, press_len=0.
REQ-026 Reset mid-press (any state) SHALL produce no release_pulse or press_len update; after release a still-held button re-debounces from IDLE and produces a fresh press_pulse.

Verification
REQ-027 DEBOUNCE_CYCLES=4, ACTIVE_LOW=1: gpio_in 1->0 before edge 0, held -> press_pulse high between edges 6 and 7, pressed=1 from edge 6.
REQ-028 DEBOUNCE_CYCLES=4: gpio_in low for 3 cycles then high -> no press_pulse, pressed stays 0, FSM returns to IDLE.
REQ-029 Held, then 2-cycle high glitch during RELEASE_WAIT, then low -> single release_pulse only after 4 stable low samples; exactly one press_pulse for the whole sequence.
REQ-030 LONG_PRESS_CYCLES=20, press held 50 cycles -> one long_pulse when duration=20; press_len = duration at release (≥ 50, checked against model).
REQ-031 LONG_PRESS_CYCLES=20, press held 10 cycles -> no long_pulse, press_len updated once on release_pulse.
REQ-032 rst_n pulsed low while in HELD -> all outputs 0 immediately, no release_pulse; pin still pressed -> new press_pulse DEBOUNCE_CYCLES+2 edges after rst_n rises.
